// File: rtl/eth_pkg.sv
// Shared constants and FSM state encoding for the 10BASE-T frame transmitter.
// States: IDLE wait/NLP | PREAMBLE 0x55 bytes | SFD | DATA payload | PAD zeros | FCS | SOI high | IPG low
package eth_pkg;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_SOI      = 3'd6,
    ST_IPG      = 3'd7
  } state_t;

endpackage

// File: rtl/eth_crc32_serial.sv
// Bit-serial MSB-first CRC-32 register; callers qualify every control with the half-bit strobe.
module eth_crc32_serial
  import eth_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic init_i,
  input  logic shift_in_i,
  input  logic bit_i,
  input  logic shift_out_i,
  output logic msb_o
);

  logic [31:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (shift_in_i) begin
      crc_d = {crc_q[30:0], 1'b0} ^ ({32{bit_i ^ crc_q[31]}} & CRC_POLY);
    end else if (shift_out_i) begin
      crc_d = {crc_q[30:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign msb_o = crc_q[31];

endmodule

// File: rtl/eth_tx10_frame.sv
// 10BASE-T frame transmitter: preamble, SFD, BRAM payload, pad, FCS, SOI, IPG and idle NLPs,
// Manchester-encoded one half-bit per clk_stb.
module eth_tx10_frame
  import eth_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_LEN        = 60,
  parameter int PAD_EN         = 1,
  parameter int SOI_HALFBITS   = 6,
  parameter int IPG_HALFBITS   = 193,
  parameter int NLP_PERIOD     = 320000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_stb,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              tx_p,
  output logic              bram_rd_en,
  output logic [ADDR_W-1:0] bram_rd_addr,
  input  logic [7:0]        bram_rd_data
);

  localparam int LEN_W   = ADDR_W + 1;
  localparam int TMR_MAX = (IPG_HALFBITS > SOI_HALFBITS) ? IPG_HALFBITS : SOI_HALFBITS;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int NLP_W   = $clog2(NLP_PERIOD + 1);

  localparam logic [LEN_W-1:0] MAX_LEN   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LEN_W-1:0] MIN_LEN_V = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] PRE_LAST  = LEN_W'(PREAMBLE_BYTES - 1);
  localparam logic [LEN_W-1:0] FCS_LAST  = LEN_W'(3);
  localparam logic [TMR_W-1:0] SOI_LAST  = TMR_W'(SOI_HALFBITS - 1);
  localparam logic [TMR_W-1:0] IPG_LAST  = TMR_W'(IPG_HALFBITS - 1);
  localparam logic [NLP_W-1:0] NLP_TC    = NLP_W'(NLP_PERIOD);

  state_t              state_q, state_d;
  logic                pend_q, pend_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [3:0]          half_q, half_d;
  logic [LEN_W-1:0]    byte_q, byte_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [NLP_W-1:0]    nlp_q, nlp_d;
  logic [7:0]          dat_q, dat_d;
  logic [7:0]          nxt_q, nxt_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

  logic                crc_init, crc_shift_in, crc_shift_out, crc_bit, crc_msb;
  logic                cur_bit, byte_end, launch, pad_needed;
  logic [LEN_W-1:0]    byte_inc, len_eff;

  assign byte_inc   = byte_q + LEN_W'(1);
  assign byte_end   = (half_q == 4'd15);
  assign len_eff    = (len > MAX_LEN) ? MAX_LEN : len;
  assign pad_needed = (PAD_EN != 0) && (len_q < MIN_LEN_V);
  // An NLP due on this strobe wins; a pending frame launches on the following strobe.
  assign launch     = clk_stb && (state_q == ST_IDLE) && pend_q && (nlp_q != NLP_TC);

  always_comb begin
    cur_bit = 1'b0;
    case (state_q)
      ST_PREAMBLE: cur_bit = PREAMBLE_BYTE[half_q[3:1]];
      ST_SFD:      cur_bit = SFD_BYTE[half_q[3:1]];
      ST_DATA:     cur_bit = dat_q[half_q[3:1]];
      ST_FCS:      cur_bit = ~crc_msb;
      default:     cur_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    len_d         = len_q;
    half_d        = half_q;
    byte_d        = byte_q;
    tmr_d         = tmr_q;
    nlp_d         = nlp_q;
    dat_d         = dat_q;
    nxt_d         = nxt_q;
    tx_d          = tx_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    rd_en_d       = rd_en_q;
    rd_addr_d     = rd_addr_q;
    crc_init      = 1'b0;
    crc_shift_in  = 1'b0;
    crc_shift_out = 1'b0;
    crc_bit       = 1'b0;

    if ((state_q == ST_IDLE) && !launch && start && (len != '0)) begin
      pend_d = 1'b1;
      len_d  = len_eff;
    end

    if (clk_stb) begin
      case (state_q)
        ST_IDLE: begin
          tx_d = 1'b0;
          if (nlp_q == NLP_TC) begin
            tx_d  = 1'b1;
            nlp_d = '0;
          end else if (pend_q) begin
            state_d = ST_PREAMBLE;
            pend_d  = 1'b0;
            busy_d  = 1'b1;
            half_d  = '0;
            byte_d  = '0;
          end else begin
            nlp_d = nlp_q + NLP_W'(1);
          end
        end

        ST_SOI: begin
          tx_d = 1'b1;
          if (tmr_q == '0) begin
            state_d = ST_IPG;
            tmr_d   = IPG_LAST;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end

        ST_IPG: begin
          tx_d = 1'b0;
          if (tmr_q == '0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            nlp_d   = '0;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end

        default: begin
          tx_d   = cur_bit ^ ~half_q[0];
          half_d = half_q + 4'd1;
          case (state_q)
            ST_PREAMBLE: begin
              crc_init = 1'b1;
              if (byte_end) begin
                if (byte_q == PRE_LAST) begin
                  state_d = ST_SFD;
                  byte_d  = '0;
                end else begin
                  byte_d = byte_inc;
                end
              end
            end

            ST_SFD: begin
              if (half_q == 4'd13) begin
                rd_en_d   = 1'b1;
                rd_addr_d = '0;
              end
              if (half_q == 4'd14) begin
                rd_en_d = 1'b0;
                nxt_d   = bram_rd_data;
              end
              if (byte_end) begin
                state_d = ST_DATA;
                byte_d  = '0;
                dat_d   = nxt_q;
              end
            end

            ST_DATA: begin
              crc_shift_in = half_q[0];
              crc_bit      = cur_bit;
              if ((half_q == 4'd13) && (byte_inc < len_q)) begin
                rd_en_d   = 1'b1;
                rd_addr_d = ADDR_W'(byte_inc);
              end
              if (half_q == 4'd14) begin
                rd_en_d = 1'b0;
                nxt_d   = bram_rd_data;
              end
              if (byte_end) begin
                if (byte_inc == len_q) begin
                  // Keep counting through the pad so PAD ends at MIN_LEN total bytes.
                  byte_d  = byte_inc;
                  state_d = pad_needed ? ST_PAD : ST_FCS;
                  if (!pad_needed) begin
                    byte_d = '0;
                  end
                end else begin
                  byte_d = byte_inc;
                  dat_d  = nxt_q;
                end
              end
            end

            ST_PAD: begin
              crc_shift_in = half_q[0];
              crc_bit      = 1'b0;
              if (byte_end) begin
                if (byte_inc == MIN_LEN_V) begin
                  state_d = ST_FCS;
                  byte_d  = '0;
                end else begin
                  byte_d = byte_inc;
                end
              end
            end

            ST_FCS: begin
              crc_shift_out = half_q[0];
              if (byte_end) begin
                if (byte_q == FCS_LAST) begin
                  state_d = ST_SOI;
                  tmr_d   = SOI_LAST;
                end else begin
                  byte_d = byte_inc;
                end
              end
            end

            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_q    <= 1'b0;
      len_q     <= '0;
      half_q    <= '0;
      byte_q    <= '0;
      tmr_q     <= '0;
      nlp_q     <= '0;
      dat_q     <= '0;
      nxt_q     <= '0;
      tx_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      len_q     <= len_d;
      half_q    <= half_d;
      byte_q    <= byte_d;
      tmr_q     <= tmr_d;
      nlp_q     <= nlp_d;
      dat_q     <= dat_d;
      nxt_q     <= nxt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  eth_crc32_serial u_crc (
    .clk         (clk),
    .rst         (rst),
    .init_i      (crc_init),
    .shift_in_i  (crc_shift_in),
    .bit_i       (crc_bit),
    .shift_out_i (crc_shift_out),
    .msb_o       (crc_msb)
  );

  assign tx_p         = tx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign bram_rd_en   = rd_en_q;
  assign bram_rd_addr = rd_addr_q;

endmodule

// File: doc/eth_tx10_frame.md
# eth_tx10_frame

Parametrised 10BASE-T frame transmitter. Each frame's payload is read from a frame BRAM and Manchester-encoded onto a single line output, one half-bit per `clk_stb`. The block generates preamble, SFD, optional minimum-length zero padding, FCS, start-of-idle (SOI), inter-packet gap and normal link pulses (NLP). It replaces the fixed-length transmitter: frame length is per-frame and runtime, start is latched between strobes, and completion is signalled.

## Interface
- `ADDR_W`, 10: BRAM byte-address width; max frame payload 2^ADDR_W bytes.
- `PREAMBLE_BYTES`, 7: count of 0x55 bytes before the SFD.
- `MIN_LEN`, 60: minimum payload bytes, excluding FCS.
- `PAD_EN`, 1: 1 = zero-pad payloads shorter than MIN_LEN.
- `SOI_HALFBITS`, 6: strobes of tx_p high after the FCS.
- `IPG_HALFBITS`, 193: strobes of tx_p low after SOI.
- `NLP_PERIOD`, 320000: idle strobes between link pulses.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `clk_stb` in 1: half-bit strobe, nominally 20 MHz; one `clk` wide.
- `start` in 1: one-`clk` request pulse. Does not need to coincide with `clk_stb`.
- `len` in ADDR_W+1: payload byte count. Sampled with `start`. Values above 2^ADDR_W clamp to 2^ADDR_W.
- `busy` out 1: high from frame acceptance until IPG ends.
- `done` out 1: one-`clk` pulse on the strobe at which IPG completes.
- `tx_p` out 1: line output.
- `bram_rd_en` out 1: BRAM read enable.
- `bram_rd_addr` out ADDR_W: BRAM byte address.
- `bram_rd_data` in 8: BRAM read data; 1-`clk` read latency.

## Operation
- Reset values: all outputs 0; state IDLE; pending flag, length register and NLP counter all 0.
- `start` sets a pending flag on any `clk` while in IDLE, capturing `len` at the same time.
- `start` is ignored while `busy`.
- `start` with `len`==0 is ignored: no pending flag, `busy` stays 0.
- States:
  - IDLE: on a strobe with pending set, go to PREAMBLE and clear pending.
  - PREAMBLE: after PREAMBLE_BYTES bytes, go to SFD.
  - SFD: after 1 byte, go to DATA.
  - DATA: after L bytes, go to PAD if PAD_EN and L<MIN_LEN, otherwise go to FCS.
  - PAD: after MIN_LEN−L zero bytes, go to FCS.
  - FCS: after 32 bits, go to SOI.
  - SOI: after SOI_HALFBITS strobes, go to IPG.
  - IPG: after IPG_HALFBITS strobes, go to IDLE and pulse `done`.
- Byte serialisation: LSB first, 16 strobes per byte.
- Manchester encoding of bit b: first half-strobe drives ~b, second half-strobe drives b.
- BRAM prefetch:
  - For each DATA byte k, `bram_rd_addr`=k and `bram_rd_en`=1 for one strobe, at half-bit 13 of the preceding byte.
  - The data is captured at half-bit 14 of the preceding byte.
  - Byte 0 is fetched during SFD.
  - `bram_rd_en` is 0 at all other times.
- CRC:
  - Initialised to 0xFFFFFFFF during PREAMBLE.
  - Updated once per DATA and PAD bit b: crc ← (crc<<1) ^ ({32{b^crc[31]}} & 0x04C11DB7).
  - FCS bits are emitted MSB-first as ~crc[31], Manchester-encoded, with crc shifting left once per bit.
- NLP:
  - In IDLE, a counter increments per strobe.
  - When the counter equals NLP_PERIOD, `tx_p`=1 for that strobe and the counter clears.
  - The counter holds while `busy` and clears on the IPG→IDLE transition.
  - `tx_p`=0 on all other IDLE strobes.
- Pending start and NLP on the same strobe: the NLP pulse is emitted, and the frame begins on the next strobe.

## Timing
- All state and output updates occur only on `clk` edges with `clk_stb`=1. Exceptions: the `start` latch, and `done`, which falls on the next `clk`.
- `busy` rises on the strobe that enters PREAMBLE and falls with `done`.
- Frame duration in strobes: 16·(PREAMBLE_BYTES+1+L') + 64 + SOI_HALFBITS + IPG_HALFBITS, where L' = max(L, MIN_LEN) if PAD_EN, else L.
- The first preamble half-bit appears on `tx_p` at the strobe after `busy` rises.
- `rst` mid-frame:
  - Immediately forces `tx_p`=0, `bram_rd_en`=0, `busy`=0 and state IDLE, and clears pending.
  - No FCS or SOI is emitted for the aborted frame.

## Structure
- Package `eth_pkg` holds:
  - CRC_INIT = 0xFFFFFFFF and CRC_POLY = 0x04C11DB7.
  - PREAMBLE_BYTE = 0x55 and SFD_BYTE = 0xD5.
  - The 3-bit state enum.
- Sub-module `eth_crc32_serial` is a bit-serial CRC register with `init`, `shift_in(bit)` and `shift_out` controls; it is instantiated once.
- Byte/half-bit counters and the FSM live in the top module.

## Test plan
- Reset, idle with NLP_PERIOD=100 → one-strobe `tx_p` pulse every 101 strobes; no `bram_rd_en`.
- `len`=64, known payload → decoded stream is 7×0x55, 0xD5, the 64 bytes, then an FCS equal to the IEEE CRC-32 of the payload; `done` after 16·72+64+6+193 strobes.
- `len`=14, PAD_EN=1 → 60 payload bytes on the line (46 zeros); FCS covers the padded 60 bytes; exactly 14 `bram_rd_en` pulses, at addresses 0..13.
- `start` pulse between strobes → frame starts; a second `start` while `busy` → ignored; `len`=0 → `busy` stays 0.
- `rst` asserted at DATA byte 20 → `tx_p`, `busy` and `bram_rd_en` go 0 asynchronously; a following `start` with `len`=64 produces a complete, correct frame.
